// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational IM, and hands
// registered words to decode over valid/ready. Optional counters: FETCH_PERF_CNT_EN.
module fetch_ctrl #(
  parameter int          ADDR_W   = 5,
  parameter int          PROG_LEN = 30,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] addresIM,
  input  logic [31:0]       inst,
  output logic [31:0]       inst_out,
  output logic [31:0]       pc_out,
  output logic              valid_out,
  input  logic              ready_in,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              busy,
  output logic              done,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       stall_cnt,
`endif
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [29:0] PROG_LEN_W = 30'(PROG_LEN);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] inst_n, pc_out_n;
  logic        valid_n, err_n;

  logic delivered, slot_free, in_prog, bad_target;

  assign delivered  = valid_out && ready_in;
  assign slot_free  = !valid_out || delivered;
  assign in_prog    = pc[31:2] < PROG_LEN_W;
  assign bad_target = (redirect_pc[1:0] != 2'b00) || (redirect_pc[31:2] >= PROG_LEN_W);

  assign addresIM = pc[ADDR_W+1:2];
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst_out  <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      inst_out  <= inst_n;
      pc_out    <= pc_out_n;
      valid_out <= valid_n;
      err       <= err_n;
    end
  end

  // NOTE: every output of this block gets a hold value first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    inst_n   = inst_out;
    pc_out_n = pc_out;
    valid_n  = valid_out;
    err_n    = err;

    unique case (state)
      S_IDLE, S_DONE: begin
        // Redirects are ignored here; only start has any effect.
        if (start) begin
          state_n = S_RUN;
          pc_n    = RESET_PC;
          err_n   = 1'b0;
          valid_n = 1'b0;
        end
      end

      S_RUN: begin
        if (redirect_valid) begin
          // A same-cycle handshake has already delivered; anything else is flushed.
          valid_n = 1'b0;
          if (bad_target) begin
            err_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            pc_n = redirect_pc;
          end
        end else if (slot_free) begin
          if (in_prog) begin
            inst_n   = inst;
            pc_out_n = pc;
            valid_n  = 1'b1;
            pc_n     = pc + 32'd4;
          end else begin
            valid_n = 1'b0;
            state_n = S_DONE;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic start_accept;
  assign start_accept = start && (state != S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (start_accept) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (state == S_RUN) begin
      if (delivered && fetch_cnt != 16'hFFFF)
        fetch_cnt <= fetch_cnt + 16'd1;
      if (valid_out && !ready_in && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
